// File: rtl/ro_meter_pkg.sv
// Shared definitions for the ring-oscillator frequency meter:
// mode encodings, FSM state type and default parameter values.
package ro_meter_pkg;

    localparam logic [1:0] MODE_SINGLE    = 2'b00;
    localparam logic [1:0] MODE_CONT      = 2'b01;
    localparam logic [1:0] MODE_SCAN      = 2'b10;
    localparam logic [1:0] MODE_SCAN_CONT = 2'b11;

    localparam int DEF_NUM_CH     = 2;
    localparam int DEF_CNT_W      = 16;
    localparam int DEF_GATE_W     = 20;
    localparam int DEF_SETTLE_CYC = 64;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        GATE,
        REPORT
    } meter_state_t;

endpackage

// File: rtl/ro_edge_counter.sv
// Synchronises one asynchronous oscillator, detects its rising edges and
// counts them into a saturating counter with a sticky overflow flag.
module ro_edge_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             osc,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    // [0],[1] form the 2-FF synchroniser; [2] holds the previous synchronised level.
    logic [2:0] sync_q;
    logic       rise;

    assign rise = sync_q[1] & ~sync_q[2];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], osc};
            if (clr) begin
                count <= '0;
                ovf   <= 1'b0;
            end else if (en && rise) begin
                if (count == '1) begin
                    ovf <= 1'b1;
                end else begin
                    count <= count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter: enables and settles the selected oscillator,
// counts its edges over a programmable gate window, reports via valid/ready.
module ro_freq_meter
    import ro_meter_pkg::*;
#(
    parameter int  NUM_CH     = DEF_NUM_CH,
    parameter int  CNT_W      = DEF_CNT_W,
    parameter int  GATE_W     = DEF_GATE_W,
    parameter int  SETTLE_CYC = DEF_SETTLE_CYC,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] osc_in,
    output logic [NUM_CH-1:0] osc_en,
    input  logic [CH_W-1:0]   ch_sel,
    input  logic [1:0]        mode,
    input  logic              start,
    input  logic              stop,
    input  logic [GATE_W-1:0] gate_len,
    output logic              busy,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [CNT_W-1:0]  res_count,
    output logic [CH_W-1:0]   res_ch,
    output logic              res_ovf
);

    localparam int SET_W = (SETTLE_CYC > 2) ? $clog2(SETTLE_CYC) : 1;
    localparam int TMR_W = (GATE_W > SET_W) ? GATE_W : SET_W;

    meter_state_t      state, state_nx;
    logic [1:0]        mode_q;
    logic [GATE_W-1:0] gate_q;
    logic [CH_W-1:0]   ch_q;
    logic [CH_W-1:0]   next_ch;
    logic [TMR_W-1:0]  tmr_q;
    logic [TMR_W-1:0]  gate_last;
    logic              stop_q;
    logic              start_ok;
    logic              tmr_done;
    logic              last_ch;
    logic              enter_settle;
    logic              osc_sel;
    logic              osc_active;
    logic [CNT_W-1:0]  cnt;
    logic              cnt_ovf;

    assign start_ok  = start && (mode[1] || (int'(ch_sel) < NUM_CH));
    assign tmr_done  = (tmr_q == '0);
    assign last_ch   = (ch_q == CH_W'(NUM_CH - 1));
    assign next_ch   = last_ch ? '0 : ch_q + CH_W'(1);
    assign gate_last = (gate_q == '0) ? '0 : TMR_W'(gate_q) - TMR_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_ok) state_nx = SETTLE;
            SETTLE:  if (tmr_done) state_nx = GATE;
            GATE:    if (tmr_done) state_nx = REPORT;
            REPORT: begin
                if (res_ready) begin
                    // A stop seen during the handshake cycle itself also ends the run.
                    if (stop_q || stop || (mode_q == MODE_SINGLE) ||
                        ((mode_q == MODE_SCAN) && last_ch)) begin
                        state_nx = IDLE;
                    end else begin
                        state_nx = SETTLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign enter_settle = (state_nx == SETTLE) && (state != SETTLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= MODE_SINGLE;
            gate_q <= '0;
            ch_q   <= '0;
            tmr_q  <= '0;
            stop_q <= 1'b0;
        end else begin
            stop_q <= (state == IDLE) ? 1'b0 : (stop_q | stop);

            if ((state == IDLE) && start_ok) begin
                mode_q <= mode;
                gate_q <= gate_len;
                ch_q   <= mode[1] ? '0 : ch_sel;
            end else if ((state == REPORT) && res_ready && mode_q[1]) begin
                ch_q <= next_ch;
            end

            if (enter_settle) begin
                tmr_q <= TMR_W'(SETTLE_CYC - 1);
            end else if ((state == SETTLE) && tmr_done) begin
                tmr_q <= gate_last;
            end else if (!tmr_done) begin
                tmr_q <= tmr_q - TMR_W'(1);
            end
        end
    end

    assign osc_active = (state == SETTLE) || (state == GATE);

    always_comb begin
        osc_en  = '0;
        osc_sel = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ch_q == CH_W'(i)) begin
                osc_en[i] = osc_active;
                osc_sel   = osc_in[i];
            end
        end
    end

    ro_edge_counter #(
        .CNT_W(CNT_W)
    ) u_counter (
        .clk  (clk),
        .reset(reset),
        .clr  (enter_settle),
        .en   (state == GATE),
        .osc  (osc_sel),
        .count(cnt),
        .ovf  (cnt_ovf)
    );

    assign busy      = (state != IDLE);
    assign res_valid = (state == REPORT);
    assign res_count = res_valid ? cnt : '0;
    assign res_ch    = res_valid ? ch_q : '0;
    assign res_ovf   = res_valid & cnt_ovf;

endmodule

// File: tb/tb_ro_freq_meter.sv
// Randomised scoreboard bench for ro_freq_meter: expected results are queued at
// each start and checked by an independent monitor whenever res_valid is high.
module tb_ro_freq_meter;
    import ro_meter_pkg::*;

    localparam int NUM_CH     = 3;
    localparam int CNT_W      = 8;
    localparam int GATE_W     = 12;
    localparam int SETTLE_CYC = 64;
    localparam int CH_W       = 2;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NUM_CH-1:0] osc_in;
    logic [NUM_CH-1:0] osc_en;
    logic [CH_W-1:0]   ch_sel = '0;
    logic [1:0]        mode = MODE_SINGLE;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic [GATE_W-1:0] gate_len = '0;
    logic              busy;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic [CNT_W-1:0]  res_count;
    logic [CH_W-1:0]   res_ch;
    logic              res_ovf;

    always #5 clk = ~clk;

    ro_freq_meter #(
        .NUM_CH    (NUM_CH),
        .CNT_W     (CNT_W),
        .GATE_W    (GATE_W),
        .SETTLE_CYC(SETTLE_CYC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .osc_in   (osc_in),
        .osc_en   (osc_en),
        .ch_sel   (ch_sel),
        .mode     (mode),
        .start    (start),
        .stop     (stop),
        .gate_len (gate_len),
        .busy     (busy),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_count(res_count),
        .res_ch   (res_ch),
        .res_ovf  (res_ovf)
    );

    typedef struct {
        int ch;
        int lo;
        int hi;
        int ovf;   // 0, 1, or 2 when the saturation boundary makes it ambiguous
    } exp_t;

    exp_t sb[$];
    int   per[NUM_CH] = '{default: 10};
    int   ph[NUM_CH]  = '{default: 0};
    int   n_vec = 0;
    int   n_err = 0;
    int   n_hs  = 0;
    int   force_lo = 0;

    task automatic check(input string name, input int act, input int lo, input int hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d..%0d at %0t", name, act, lo, hi, $time);
        end
    endtask

    task automatic note_fail(input string name, input int act, input int want);
        n_vec++;
        n_err++;
        $display("FAIL %s: got %0d, want %0d at %0t", name, act, want, $time);
    endtask

    // Oscillator edges land 2 ns past a half-cycle boundary, never on a clk edge.
    initial begin
        int k;
        k = 0;
        osc_in = '0;
        #2;
        forever begin
            for (int i = 0; i < NUM_CH; i++)
                osc_in[i] = ((k + ph[i]) % (2 * per[i])) < per[i];
            k++;
            #5;
        end
    end

    always @(posedge clk) begin
        #1;
        res_ready = (force_lo != 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    function automatic exp_t mk_exp(input int ch, input int g);
        exp_t e;
        int ge, p;
        ge = (g == 0) ? 1 : g;
        p = per[ch];
        e.ch = ch;
        e.lo = ge / p - 1;
        if (e.lo < 0) e.lo = 0;
        e.hi = (ge + p - 1) / p + 1;
        if (e.lo > CNT_MAX) begin
            e.lo = CNT_MAX;
            e.hi = CNT_MAX;
            e.ovf = 1;
        end else if (e.hi < CNT_MAX) begin
            e.ovf = 0;
        end else begin
            if (e.hi > CNT_MAX) e.hi = CNT_MAX;
            e.ovf = 2;
        end
        return e;
    endfunction

    // Monitor: every cycle a result is presented it must match the queue head.
    logic [NUM_CH-1:0] prev_en = '0;
    always @(negedge clk) begin
        if (reset) begin
            prev_en = '0;
        end else begin
            if (res_valid) begin
                if (sb.size() == 0) begin
                    note_fail("unexpected_result", int'(res_ch), -1);
                end else begin
                    check("res_ch", int'(res_ch), sb[0].ch, sb[0].ch);
                    check("res_count", int'(res_count), sb[0].lo, sb[0].hi);
                    if (sb[0].ovf != 2) check("res_ovf", int'(res_ovf), sb[0].ovf, sb[0].ovf);
                    check("osc_en_in_report", int'(osc_en), 0, 0);
                    if (res_ready) begin
                        void'(sb.pop_front());
                        n_hs++;
                    end
                end
            end
            if (osc_en != '0 && osc_en != prev_en) begin
                if (sb.size() == 0) note_fail("spurious_osc_en", int'(osc_en), 0);
                else check("osc_en", int'(osc_en), 1 << sb[0].ch, 1 << sb[0].ch);
            end
            prev_en = osc_en;
        end
    end

    task automatic scramble();
        mode     = 2'($urandom);
        ch_sel   = CH_W'($urandom);
        gate_len = GATE_W'($urandom);
        start    = busy ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    task automatic launch(input logic [1:0] m, input int ch, input int g, input int n, input bit scr);
        int ge, k;
        ge = (g == 0) ? 1 : g;
        case (m)
            MODE_SINGLE: sb.push_back(mk_exp(ch, g));
            MODE_CONT:   for (int i = 0; i < n; i++) sb.push_back(mk_exp(ch, g));
            MODE_SCAN:   for (int i = 0; i < NUM_CH; i++) sb.push_back(mk_exp(i, g));
            default:     for (int i = 0; i < n; i++) sb.push_back(mk_exp(i % NUM_CH, g));
        endcase
        mode     = m;
        ch_sel   = CH_W'(ch);
        gate_len = GATE_W'(g);
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        while (!res_valid && k < 5000) begin
            if (scr) scramble();
            @(negedge clk);
            k++;
        end
        check("latency", k, 1 + SETTLE_CYC + ge, 1 + SETTLE_CYC + ge);
    endtask

    task automatic wait_done(input bit scr);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 20000) begin
            if (scr) scramble();
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            note_fail("result_timeout", sb.size(), 0);
            sb.delete();
        end
        start = 1'b0;
        @(negedge clk);
        check("busy_after_run", int'(busy), 0, 0);
    endtask

    task automatic wait_hs(input int target);
        int k;
        k = 0;
        while (n_hs < target && k < 20000) begin
            @(negedge clk);
            k++;
        end
        if (n_hs < target) note_fail("handshake_timeout", n_hs, target);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_osc_en"}, int'(osc_en), 0, 0);
        check({tag, "_busy"}, int'(busy), 0, 0);
        check({tag, "_res_valid"}, int'(res_valid), 0, 0);
        check({tag, "_res_count"}, int'(res_count), 0, 0);
        check({tag, "_res_ch"}, int'(res_ch), 0, 0);
        check({tag, "_res_ovf"}, int'(res_ovf), 0, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: %0d vectors, %0d miscompares before timeout", n_vec, n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base, g, sel, ch;
        logic [1:0] m;

        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // Single measurement, 10-cycle oscillator, 1000-cycle gate.
        per[1] = 10;
        launch(MODE_SINGLE, 1, 1000, 1, 1'b0);
        wait_done(1'b0);

        // Saturation and overflow.
        per[2] = 4;
        launch(MODE_SINGLE, 2, 2000, 1, 1'b0);
        wait_done(1'b0);

        // Scan-once over all channels; ch_sel is irrelevant in scan modes.
        per[0] = 8;
        per[1] = 16;
        per[2] = 12;
        launch(MODE_SCAN, 3, 800, 0, 1'b0);
        wait_done(1'b0);

        // Continuous with back-pressure, then stop.
        per[0] = $urandom_range(5, 40);
        base = n_hs;
        force_lo = 1;
        launch(MODE_CONT, 0, 200, 3, 1'b0);
        repeat (50) begin
            @(negedge clk);
            check("hold_valid", int'(res_valid), 1, 1);
            check("hold_busy", int'(busy), 1, 1);
        end
        force_lo = 0;
        wait_hs(base + 2);
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_done(1'b0);
        repeat (300) @(negedge clk);

        // Scan-continuous wraps channels until stopped.
        for (int c = 0; c < NUM_CH; c++) per[c] = $urandom_range(5, 40);
        base = n_hs;
        launch(MODE_SCAN_CONT, 0, $urandom_range(50, 150), 5, 1'b0);
        wait_hs(base + 4);
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_done(1'b0);
        repeat (200) @(negedge clk);

        // Reset in the middle of a gate discards the measurement.
        per[0] = 9;
        sb.push_back(mk_exp(0, 500));
        mode = MODE_SINGLE;
        ch_sel = 0;
        gate_len = 500;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (SETTLE_CYC + 100) @(negedge clk);
        check("mid_gate_busy", int'(busy), 1, 1);
        check("mid_gate_osc_en", int'(osc_en), 1, 1);
        reset = 1'b1;
        @(negedge clk);
        check_zero_outputs("mid_gate_reset");
        sb.delete();
        reset = 1'b0;
        repeat (700) @(negedge clk);
        check("after_reset_busy", int'(busy), 0, 0);

        // Out-of-range channel in single/continuous modes is rejected.
        for (int i = 0; i < 2; i++) begin
            mode = (i == 0) ? MODE_SINGLE : MODE_CONT;
            ch_sel = 2'd3;
            gate_len = 100;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            check("bad_ch_busy", int'(busy), 0, 0);
            check("bad_ch_osc_en", int'(osc_en), 0, 0);
        end

        // Random runs with inputs churned and start re-pulsed while busy.
        for (int it = 0; it < 14; it++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                per[c] = $urandom_range(5, 40);
                ph[c]  = $urandom_range(0, 79);
            end
            repeat (4) @(negedge clk);
            sel = $urandom_range(0, 3);
            ch  = $urandom_range(0, NUM_CH - 1);
            g   = (it < 2) ? it : $urandom_range(2, 300);
            m   = (sel == 3) ? MODE_SCAN : MODE_SINGLE;
            launch(m, ch, g, 1, 1'b1);
            wait_done(1'b1);
        end

        repeat (20) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ro_freq_meter.md
RO_FREQ_METER -- requirements
Module: ro_freq_meter

Interface
REQ-001 Parameter NUM_CH, default 2: number of ring-oscillator channels; range 1..16.
REQ-002 Parameter CNT_W, default 16: edge-count result width.
REQ-003 Parameter GATE_W, default 20: gate-length width, in clk cycles.
REQ-004 Parameter SETTLE_CYC, default 64: oscillator start-up cycles that are discarded before each gate; must be ≥4.
REQ-005 Derived constant CH_W = max(1, clog2(NUM_CH)).
REQ-006 Ports: clk (input, 1) is the single clock; reset (input, 1) is synchronous, active-high.
REQ-007 osc_in (input, NUM_CH): raw oscillator outputs, asynchronous to clk.
REQ-008 osc_en (output, NUM_CH): per-oscillator enable.
REQ-009 ch_sel (input, CH_W): channel for the single/continuous modes.
REQ-010 mode (input, 2): 00 single, 01 continuous, 10 scan-once, 11 scan-continuous.
REQ-011 start (input, 1) begins a measurement run; stop (input, 1) ends a continuous run.
REQ-012 gate_len (input, GATE_W): gate window length in clk cycles.
REQ-013 busy (output, 1): run in progress.
REQ-014 res_valid (output, 1) / res_ready (input, 1): result handshake.
REQ-015 Result fields: res_count (output, CNT_W), res_ch (output, CH_W), res_ovf (output, 1).

Function
REQ-016 FSM states are IDLE, SETTLE, GATE, REPORT.
REQ-017 IDLE→SETTLE on start=1, provided that for modes 00/01 ch_sel<NUM_CH.
  - Otherwise start is ignored and busy stays 0.
  - mode, ch_sel and gate_len are latched at this transition.
  - Scan modes begin at channel 0.
REQ-018 A latched gate_len of 0 is treated as 1.
REQ-019 SETTLE lasts exactly SETTLE_CYC cycles, then the FSM enters GATE.
  - The counter clears on SETTLE entry.
  - The edge detector is primed so that the first GATE cycle cannot count a stale edge.
REQ-020 GATE lasts exactly the latched gate_len cycles, then the FSM enters REPORT.
REQ-021 Edge counting:
  - The selected osc_in passes through a channel mux, then a 2-FF synchroniser, then a rising-edge detector.
  - Each detected edge in a GATE cycle increments the count by 1.
  - Accuracy is ±1 count for oscillator frequency < f_clk/4.
REQ-022 Count saturates at 2^CNT_W−1, and res_ovf is set for that result.
REQ-023 osc_en is one-hot on the active channel during SETTLE and GATE, and all-zero in IDLE and REPORT.
REQ-024 REPORT asserts res_valid with res_count, res_ch and res_ovf.
  - These hold stable until the cycle in which res_valid & res_ready.
  - res_valid drops the cycle after the handshake.
REQ-025 After the handshake, per mode:
  - 00 goes to IDLE.
  - 01 goes to SETTLE on the same channel.
  - 10 goes to SETTLE on the next channel, or to IDLE after channel NUM_CH−1.
  - 11 goes to SETTLE on the next channel, wrapping NUM_CH−1→0.
REQ-026 stop=1 in any non-IDLE cycle sets a sticky stop request.
  - The run ends in IDLE after the current REPORT handshake.
  - The request clears in IDLE.
REQ-027 start while busy=1 is ignored.
REQ-028 Mid-run changes to mode, ch_sel or gate_len have no effect until the next start.
REQ-029 busy=1 in SETTLE, GATE and REPORT.
REQ-030 Latency from start to res_valid is 1+SETTLE_CYC+gate_len cycles: start sampled in cycle t gives res_valid=1 in cycle t+1+SETTLE_CYC+gate_len.

Reset
REQ-031 reset=1 at a clk edge forces IDLE from any state, including mid-GATE and mid-REPORT.
  - osc_en=0, busy=0, res_valid=0, res_count=0, res_ch=0, res_ovf=0.
  - The stop request and the synchronisers are cleared.
REQ-032 An in-flight result is discarded on reset and is never presented.

Structure
REQ-033 Package ro_meter_pkg holds:
  - the mode encoding constants (MODE_SINGLE, MODE_CONT, MODE_SCAN, MODE_SCAN_CONT);
  - the FSM state typedef;
  - the default parameter values.
REQ-034 One sub-module, ro_edge_counter, contains the synchroniser, edge detector and saturating counter.
  - Its ports are clk, reset, clr, en, osc, count and ovf.
  - The FSM, the channel mux and the handshake stay in ro_freq_meter.

Verification
REQ-035 Single mode, NUM_CH=2, ch_sel=1, osc1 period 10 clk, gate_len=1000, SETTLE_CYC=64 → one result: res_count∈{99,100,101}, res_ch=1, res_ovf=0; res_valid rises 1065 cycles after start; busy then falls.
REQ-036 CNT_W=8, osc period 4 clk, gate_len=2000 → res_count=255, res_ovf=1.
REQ-037 Scan-once, NUM_CH=2, osc0 period 8 clk, osc1 period 16 clk, gate_len=800 → two results in order: (ch0, ≈100) then (ch1, ≈50); osc_en=01 then 10; IDLE afterwards.
REQ-038 Continuous mode with res_ready held low 50 cycles → result stable, osc_en=0, no new SETTLE; after the handshake the next SETTLE starts; stop pulse → exactly one further result, then IDLE.
REQ-039 reset pulse mid-GATE → next cycle all outputs 0, no res_valid; start with ch_sel=3 on NUM_CH=2 → ignored, busy stays 0.
